spu_bwd: RTL



---
 rtl/spu_bwd_if.sv | 21 ++
 rtl/spu_bwd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spu_bwd_if.sv
// Operand/result handshake bundle for the sigmoid backward unit.
// The master drives operands and out_ready; the slave (spu_bwd) returns the result.
interface spu_bwd_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y_float;
  logic [31:0] g_float;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_float;

  modport master (
    output in_valid, y_float, g_float, out_ready,
    input  in_ready, out_valid, d_float
  );

  modport slave (
    input  in_valid, y_float, g_float, out_ready,
    output in_ready, out_valid, d_float
  );
endinterface

// File: rtl/spu_bwd.sv
// Sigmoid backward pass: d = g*y*(1-y) in float32 via a Q0.16 derivative and one
// shared shift-add multiplier. Optional clamp statistics under SPU_BWD_STATS_EN.
module spu_bwd (
  input  logic       clk,
  input  logic       rst_n,
  spu_bwd_if.slave   bus
`ifdef SPU_BWD_STATS_EN
  ,
  output logic [15:0] clamp_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL_S  = 3'd2,
    MUL_D  = 3'd3,
    NORM   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // y in [2^-16, 1.0) maps to floor(y*65536); everything else yields 0.
  function automatic logic [15:0] y_to_fix(input logic [31:0] y);
    logic [7:0]  ey;
    logic [23:0] mant;
    logic [7:0]  sh;
    ey   = y[30:23];
    mant = {1'b1, y[22:0]};
    sh   = 8'd134 - ey;
    if (y[31] || ey < 8'd111 || ey >= 8'd127) return 16'h0000;
    return 16'(mant >> sh);
  endfunction

  function automatic logic y_is_nan(input logic [31:0] y);
    return (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
  endfunction

`ifdef SPU_BWD_STATS_EN
  function automatic logic y_clamped(input logic [31:0] y);
    if (y_is_nan(y)) return 1'b0;
    return y[31] || (y[30:23] < 8'd111) || (y[30:23] >= 8'd127);
  endfunction
`endif

  function automatic logic [5:0] lead_one(input logic [39:0] p);
    logic [5:0] k;
    k = 6'd0;
    for (int i = 0; i < 40; i++) begin
      if (p[i]) k = 6'(i);
    end
    return k;
  endfunction

  // Truncating normalisation of P = m*s; exponent underflow collapses to signed zero.
  function automatic logic [31:0] pack_norm(input logic sg, input logic [7:0] eg,
                                            input logic [39:0] p);
    logic [5:0]        k;
    logic signed [9:0] e;
    logic [39:0]       pn;
    k  = lead_one(p);
    e  = signed'({2'b00, eg}) + signed'({4'b0000, k}) - 10'sd39;
    pn = p << (6'd39 - k);
    if (e <= 10'sd0) return {sg, 31'h0};
    return {sg, 8'(e), 23'(pn >> 16)};
  endfunction

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] d_q;
  logic [3:0]  cnt_q;

  logic [31:0] y_q, g_q;
  logic [39:0] acc_q, mcand_q;
  logic [15:0] mplier_q, s_q;
  logic [23:0] m_q;
  logic [7:0]  eg_q;
  logic        sg_q, g_zero_q, g_inf_q, nan_q;

  logic        accept;
  logic [15:0] y_fix;
  logic [39:0] sum_d;
  logic [31:0] res_d;

  assign accept = bus.in_valid && in_ready_q;
  assign y_fix  = y_to_fix(y_q);
  assign sum_d  = acc_q + (mplier_q[0] ? mcand_q : 40'd0);

  always_comb begin
    res_d = pack_norm(sg_q, eg_q, acc_q);
    if (nan_q)
      res_d = 32'h7FC00000;
    else if (g_inf_q)
      res_d = (s_q != 16'h0) ? {sg_q, 8'hFF, 23'h0} : 32'h7FC00000;
    else if (g_zero_q || s_q == 16'h0)
      res_d = {sg_q, 31'h0};
  end

  // Control and registered outputs.
`ifdef SPU_BWD_STATS_EN
  logic [15:0] clamp_cnt_q;
  assign clamp_cnt = clamp_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= 32'h0;
      cnt_q       <= 4'd0;
`ifdef SPU_BWD_STATS_EN
      clamp_cnt_q <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= UNPACK;
            in_ready_q <= 1'b0;
          end
        end
        UNPACK: begin
          state_q <= MUL_S;
          cnt_q   <= 4'd0;
`ifdef SPU_BWD_STATS_EN
          if (y_clamped(y_q) && clamp_cnt_q != 16'hFFFF)
            clamp_cnt_q <= clamp_cnt_q + 16'd1;
`endif
        end
        MUL_S: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= MUL_D;
        end
        MUL_D: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= NORM;
        end
        NORM: begin
          d_q         <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture, unpack and the shared shift-add multiplier.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (accept) begin
          y_q <= bus.y_float;
          g_q <= bus.g_float;
        end
      end
      UNPACK: begin
        acc_q    <= 40'd0;
        mcand_q  <= {24'd0, y_fix};
        mplier_q <= (y_fix == 16'h0) ? 16'h0 : 16'(17'h10000 - {1'b0, y_fix});
        sg_q     <= g_q[31];
        eg_q     <= g_q[30:23];
        m_q      <= {1'b1, g_q[22:0]};
        g_zero_q <= (g_q[30:23] == 8'h00);
        g_inf_q  <= (g_q[30:23] == 8'hFF) && (g_q[22:0] == 23'h0);
        nan_q    <= y_is_nan(y_q) || y_is_nan(g_q);
      end
      MUL_S: begin
        if (cnt_q == 4'd15) begin
          s_q      <= sum_d[31:16];
          acc_q    <= 40'd0;
          mcand_q  <= {16'd0, m_q};
          mplier_q <= sum_d[31:16];
        end else begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
      end
      MUL_D: begin
        acc_q    <= sum_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.d_float   = d_q;

endmodule
